pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 core. Sits beside the F/D/E/M/W pipeline registers.
- Generates stall and bubble controls for load/use hazards, ret and mispredicted jumps.
- Gates set_cc on exceptions, and runs a RUN/PAUSE/HALT sequencer that supports debug pause/single-step.
- Maintains performance counters for cycles and retired instructions.

Parameters:
CNT_W, 64, width of cycle and retired-instruction counters
STAT_AOK, 2'd0, status code: normal
STAT_HLT, 2'd1, status code: halt executed
STAT_ADR, 2'd2, status code: bad address
STAT_INS, 2'd3, status code: illegal instruction

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
D_icode  in  4  icode in decode
d_srcA  in  4  decode source register A (4'hF = none)
d_srcB  in  4  decode source register B
E_icode  in  4  icode in execute
E_dstM  in  4  execute load destination
e_Cnd  in  1  execute condition outcome
M_icode  in  4  icode in memory
m_stat  in  2  memory-stage status after access
W_stat  in  2  writeback status
W_icode  in  4  writeback icode
pause_req  in  1  level: request debug pause
step  in  1  pulse: advance one cycle while paused
F_stall  out  1  hold fetch PC register
D_stall  out  1  hold D register
D_bubble  out  1  load nop into D
E_bubble  out  1  load nop into E
M_bubble  out  1  load nop into M
W_stall  out  1  hold W register
set_cc  out  1  allow CC update in execute
state  out  2  sequencer state (0 RUN, 1 PAUSE, 2 HALT)
halt_stat  out  2  status that caused HALT
cycle_cnt  out  CNT_W  cycles spent in RUN, or PAUSE with a step
instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n=0): state=RUN, halt_stat=AOK, cycle_cnt=0, instr_cnt=0. All control outputs follow the combinational rules below from state RUN.
- Control outputs are combinational from inputs and the registered state (0-cycle latency). State and counters update on the rising clk edge.
- Hazard terms, evaluated in RUN:
  - lu = (E_icode in {MRMOVQ=5, POPQ=B}) and E_dstM != F and E_dstM in {d_srcA, d_srcB}.
  - rt = RET(9) in any of D_icode, E_icode, M_icode.
  - mp = E_icode==JXX(7) and !e_Cnd.
  - exc = m_stat!=AOK or W_stat!=AOK.
- RUN outputs:
  - F_stall = lu | rt.
  - D_stall = lu.
  - D_bubble = mp | (!lu & rt).
  - E_bubble = mp | lu.
  - M_bubble = exc.
  - W_stall = W_stat!=AOK.
  - set_cc = E_icode==OPQ(6) & !exc.
- PAUSE outputs:
  - If step=0: F_stall=1, D_stall=1, E_bubble=1, D_bubble=0, M_bubble/W_stall/set_cc per RUN rules. Younger stages freeze and older stages drain.
  - If step=1: outputs equal the RUN outputs for that one cycle.
- HALT outputs: F_stall=1, D_stall=1, W_stall=1, E_bubble=1, M_bubble=1, D_bubble=0, set_cc=0.
- Transitions:
  - RUN -> HALT when W_stat!=AOK. Latch halt_stat=W_stat.
  - RUN -> PAUSE when pause_req=1 (HALT has priority if both are true).
  - PAUSE -> RUN when pause_req=0.
  - PAUSE -> HALT when W_stat!=AOK and step=1.
  - HALT is absorbing until reset.
- Counters:
  - cycle_cnt increments in RUN, or in PAUSE with step=1.
  - instr_cnt increments under the same condition, when additionally W_icode!=NOP(1), W_stat==AOK and W_stall=0.
  - Both wrap modulo 2^CNT_W and freeze in HALT.
- Simultaneous events:
  - lu & mp cannot both occur (E holds one instruction).
  - lu & rt: stall wins, D_bubble=0.
  - step while not in PAUSE is ignored.
  - Reset mid-PAUSE or mid-HALT returns to RUN with counters cleared.

Decomposition:
- Shared package: icode constants (HALT..POPQ, NOP), RNONE=4'hF, status codes, sequencer state encoding.
- One sub-module, pipe_hazard: pure combinational lu/rt/mp/exc detection.
- pipe_ctrl owns the FSM, output muxing and counters.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0. With d_srcA=4, d_srcB=F -> all 0.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. With e_Cnd=1 -> all 0.
- Ret: D_icode=9 for 3 cycles -> F_stall=1 and D_bubble=1 each cycle. Add a coincident lu -> D_bubble=0, D_stall=1.
- Exception: m_stat=ADR, E_icode=6 -> M_bubble=1, set_cc=0. Next cycle W_stat=ADR -> W_stall=1, then state=2, halt_stat=2, counters frozen.
- Pause/step: pause_req=1 in RUN -> state=1 next edge. Hold 4 cycles with no step -> cycle_cnt unchanged. One step pulse -> cycle_cnt +1, F_stall=0 that cycle.
- Counters/reset: 10 RUN cycles with 6 non-nop AOK retires -> cycle_cnt=10, instr_cnt=6. Pulse rst_n low mid-cycle -> immediate state=0, counters=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - Y86-64 icodes, status codes and sequencer states for pipe_ctrl
package pipe_ctrl_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE    = 4'hF;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_HALT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// rtl/pipe_ctrl_hazard.sv - combinational load/use, ret, mispredict and exception detection
module pipe_hazard
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [1:0] m_stat,
    input  logic [1:0] W_stat,
    output logic       lu,
    output logic       rt,
    output logic       mp,
    output logic       exc
);

    // Hazard terms: a load in E feeding a source in D, a ret in flight, a not-taken jump, a faulting older stage
    always_comb begin
        lu  = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
              (E_dstM != RNONE) &&
              ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        rt  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mp  = (E_icode == I_JXX) && !e_Cnd;
        exc = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 pipeline stall/bubble control, RUN/PAUSE/HALT sequencer and perf counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic             pause_req,
    input  logic             step,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [1:0]       state,
    output logic [1:0]       halt_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    logic       lu, rt, mp, exc;
    seq_state_t state_q, state_d;
    logic [1:0] halt_stat_d;
    logic       active;
    logic       retire;

    pipe_hazard u_hazard (
        .D_icode (D_icode),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .E_icode (E_icode),
        .E_dstM  (E_dstM),
        .e_Cnd   (e_Cnd),
        .M_icode (M_icode),
        .m_stat  (m_stat),
        .W_stat  (W_stat),
        .lu      (lu),
        .rt      (rt),
        .mp      (mp),
        .exc     (exc)
    );

    assign state = state_q;

    // Stage controls: RUN rules by default, PAUSE freezes the young stages unless stepping, HALT freezes everything
    always_comb begin
        F_stall  = lu | rt;
        D_stall  = lu;
        D_bubble = mp | (!lu & rt);
        E_bubble = mp | lu;
        M_bubble = exc;
        W_stall  = (W_stat != STAT_AOK);
        set_cc   = (E_icode == I_OPQ) & !exc;
        case (state_q)
            ST_PAUSE: begin
                if (!step) begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    E_bubble = 1'b1;
                    D_bubble = 1'b0;
                end
            end
            ST_HALT: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                D_bubble = 1'b0;
                set_cc   = 1'b0;
            end
            default: ;
        endcase
    end

    // Sequencer next state; a faulting writeback only halts when the pipeline actually advances
    always_comb begin
        state_d     = state_q;
        halt_stat_d = halt_stat;
        case (state_q)
            ST_RUN: begin
                if (W_stat != STAT_AOK) begin
                    state_d     = ST_HALT;
                    halt_stat_d = W_stat;
                end else if (pause_req) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if ((W_stat != STAT_AOK) && step) begin
                    state_d     = ST_HALT;
                    halt_stat_d = W_stat;
                end else if (!pause_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // The pipeline advances in RUN or on a debug step; only then do cycles and retirements count
    always_comb begin
        active = (state_q == ST_RUN) || ((state_q == ST_PAUSE) && step);
        retire = active && (W_icode != I_NOP) && (W_stat == STAT_AOK) && !W_stall;
    end

    // Sequencer state, halt cause and free-running (wrapping) counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            halt_stat <= STAT_AOK;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            state_q   <= state_d;
            halt_stat <= halt_stat_d;
            if (active) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (retire) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and randomized self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic        e_Cnd, pause_req, step;
    logic [1:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic [1:0]  state, halt_stat;
    logic [63:0] cycle_cnt, instr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int          m_state;
    logic [1:0]  m_hstat;
    logic [63:0] m_cyc, m_ins;
    logic [63:0] saved_c, saved_i;

    pipe_ctrl #(.CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .W_icode(W_icode),
        .pause_req(pause_req), .step(step),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
        .state(state), .halt_stat(halt_stat),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc} from the rule text
    function automatic logic [6:0] model_ctrl();
        bit is_load = (E_icode == 4'd5) || (E_icode == 4'd11);
        bit lu  = is_load && (E_dstM != 4'd15) && (E_dstM == d_srcA || E_dstM == d_srcB);
        bit rt  = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
        bit mp  = (E_icode == 4'd7) && !e_Cnd;
        bit exc = (m_stat != 2'd0) || (W_stat != 2'd0);
        bit fs, ds, db, eb, mb, ws, cc;
        if (m_state == 2) return 7'b1101110;
        fs = lu || rt;
        ds = lu;
        db = mp || (rt && !lu);
        eb = mp || lu;
        mb = exc;
        ws = (W_stat != 2'd0);
        cc = (E_icode == 4'd6) && !exc;
        if (m_state == 1 && !step) begin
            fs = 1; ds = 1; eb = 1; db = 0;
        end
        return {fs, ds, db, eb, mb, ws, cc};
    endfunction

    task automatic model_edge();
        bit adv = (m_state == 0) || (m_state == 1 && step);
        if (adv) begin
            m_cyc = m_cyc + 64'd1;
            if (W_icode != 4'd1 && W_stat == 2'd0) m_ins = m_ins + 64'd1;
        end
        if (m_state == 0) begin
            if (W_stat != 2'd0) begin m_state = 2; m_hstat = W_stat; end
            else if (pause_req) m_state = 1;
        end else if (m_state == 1) begin
            if (W_stat != 2'd0 && step) begin m_state = 2; m_hstat = W_stat; end
            else if (!pause_req) m_state = 0;
        end
    endtask

    task automatic tick();
        #1;
        chk("ctrl", {57'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc},
            {57'd0, model_ctrl()});
        @(posedge clk);
        model_edge();
        #1;
        chk("state", {62'd0, state}, m_state[63:0]);
        chk("halt_stat", {62'd0, halt_stat}, {62'd0, m_hstat});
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("instr_cnt", instr_cnt, m_ins);
    endtask

    task automatic set_idle();
        D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1; W_icode = 4'd1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b1;
        m_stat = 2'd0; W_stat = 2'd0; pause_req = 1'b0; step = 1'b0;
    endtask

    // Async reset asserted mid-cycle, checked before any edge, released on a falling edge
    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        m_state = 0; m_hstat = 2'd0; m_cyc = 64'd0; m_ins = 64'd0;
        chk("rst_state", {62'd0, state}, 64'd0);
        chk("rst_halt_stat", {62'd0, halt_stat}, 64'd0);
        chk("rst_cycle_cnt", cycle_cnt, 64'd0);
        chk("rst_instr_cnt", instr_cnt, 64'd0);
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rnd_reg();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : r[3:0];
    endfunction

    initial begin
        rst_n = 1'b1;
        set_idle();
        do_reset();

        // Counters: 10 RUN cycles, 6 of them retire a non-nop
        for (int i = 0; i < 10; i++) begin
            W_icode = (i < 6) ? 4'd6 : 4'd1;
            tick();
        end
        chk("cnt10_cycle", cycle_cnt, 64'd10);
        chk("cnt10_instr", instr_cnt, 64'd6);

        // Load/use
        set_idle();
        E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        chk("lu_F_stall", {63'd0, F_stall}, 64'd1);
        chk("lu_D_stall", {63'd0, D_stall}, 64'd1);
        chk("lu_E_bubble", {63'd0, E_bubble}, 64'd1);
        chk("lu_D_bubble", {63'd0, D_bubble}, 64'd0);
        tick();
        d_srcA = 4'd4; d_srcB = 4'hF;
        #1;
        chk("nolu_ctrl", {60'd0, F_stall, D_stall, D_bubble, E_bubble}, 64'd0);
        tick();

        // Mispredict
        set_idle();
        E_icode = 4'd7; e_Cnd = 1'b0;
        #1;
        chk("mp_bubbles_fstall", {61'd0, D_bubble, E_bubble, F_stall}, 64'b110);
        tick();
        e_Cnd = 1'b1;
        #1;
        chk("taken_ctrl", {61'd0, D_bubble, E_bubble, F_stall}, 64'd0);
        tick();

        // Ret for three cycles, then a coincident load/use
        set_idle();
        D_icode = 4'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ret_F_stall_D_bubble", {62'd0, F_stall, D_bubble}, 64'b11);
            tick();
        end
        E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        chk("ret_lu_D_bubble_D_stall", {62'd0, D_bubble, D_stall}, 64'b01);
        tick();

        // Pause, hold, single step, resume
        set_idle();
        W_icode = 4'd6;
        pause_req = 1'b1;
        tick();
        chk("pause_state", {62'd0, state}, 64'd1);
        saved_c = m_cyc;
        for (int i = 0; i < 4; i++) tick();
        chk("pause_hold_cycle", cycle_cnt, saved_c);
        step = 1'b1;
        #1;
        chk("step_F_stall", {63'd0, F_stall}, 64'd0);
        tick();
        chk("step_cycle", cycle_cnt, saved_c + 64'd1);
        step = 1'b0;
        pause_req = 1'b0;
        tick();
        chk("resume_state", {62'd0, state}, 64'd0);

        // Exception drains to HALT, counters freeze
        set_idle();
        m_stat = 2'd2; E_icode = 4'd6;
        #1;
        chk("exc_M_bubble", {63'd0, M_bubble}, 64'd1);
        chk("exc_set_cc", {63'd0, set_cc}, 64'd0);
        tick();
        m_stat = 2'd0; E_icode = 4'd1; W_stat = 2'd2;
        #1;
        chk("exc_W_stall", {63'd0, W_stall}, 64'd1);
        tick();
        chk("halt_state", {62'd0, state}, 64'd2);
        chk("halt_cause", {62'd0, halt_stat}, 64'd2);
        saved_c = cycle_cnt === 64'bx ? 64'd0 : m_cyc;
        saved_i = m_ins;
        W_stat = 2'd0; W_icode = 4'd6; step = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("halt_cycle_frozen", cycle_cnt, saved_c);
        chk("halt_instr_frozen", instr_cnt, saved_i);

        // Reset out of HALT
        do_reset();

        // Randomized segments against the reference model
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 250; i++) begin
                D_icode = 4'($urandom_range(0, 11));
                E_icode = 4'($urandom_range(0, 11));
                M_icode = 4'($urandom_range(0, 11));
                W_icode = 4'($urandom_range(0, 11));
                d_srcA  = rnd_reg();
                d_srcB  = rnd_reg();
                E_dstM  = rnd_reg();
                e_Cnd   = 1'($urandom_range(0, 1));
                m_stat  = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                W_stat  = ($urandom_range(0, 79) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
                if ($urandom_range(0, 7) == 0) pause_req = ~pause_req;
                step    = ($urandom_range(0, 2) == 0);
                tick();
            end
            do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
